mdu_unit: RTL



---
 rtl/mdu_unit_if.sv | 21 ++
 rtl/mdu_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mdu_unit_if.sv
// Execute-stage bus between the pipeline controller and the multiply/divide unit:
// request, operands, HI/LO read select, busy and read data.
interface mdu_unit_if;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        read_sel;
    logic        busy;
    logic [31:0] mdu_out;

    modport master (
        output start, mdu_op, a, b, read_sel,
        input  busy, mdu_out
    );

    modport slave (
        input  start, mdu_op, a, b, read_sel,
        output busy, mdu_out
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed when
// the op is accepted, held privately, and committed to HI/LO when the busy period ends.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    function automatic logic [63:0] mul_signed(input logic [31:0] x, input logic [31:0] y);
        return {{32{x[31]}}, x} * {{32{y[31]}}, y};
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] x, input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Sign-magnitude division: avoids the INT_MIN / -1 overflow, which wraps to INT_MIN.
    function automatic logic [63:0] div_signed(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mag_x;
        logic [31:0] mag_y;
        logic [31:0] q;
        logic [31:0] r;
        mag_x = x[31] ? (32'd0 - x) : x;
        mag_y = y[31] ? (32'd0 - y) : y;
        q     = mag_x / mag_y;
        r     = mag_x % mag_y;
        return {(x[31] ? (32'd0 - r) : r), ((x[31] ^ y[31]) ? (32'd0 - q) : q)};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] x, input logic [31:0] y);
        return {x % y, x / y};
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [31:0]      hi_r, hi_s;
    logic [31:0]      lo_r, lo_s;
    logic [31:0]      res_hi_r, res_hi_s;
    logic [31:0]      res_lo_r, res_lo_s;
    logic             busy_r;
    logic             div_zero_s;

    // A zero divisor keeps the current HI/LO as the pending result, so commit is a no-op.
    assign div_zero_s = (bus.b == 32'd0);

    // Next-state logic: accept ops in IDLE, count down and commit in BUSY.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        res_hi_s = res_hi_r;
        res_lo_s = res_lo_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.mdu_op)
                        OP_MULT: begin
                            {res_hi_s, res_lo_s} = mul_signed(bus.a, bus.b);
                            cnt_s   = CNT_MULT;
                            state_s = ST_BUSY;
                        end
                        OP_MULTU: begin
                            {res_hi_s, res_lo_s} = mul_unsigned(bus.a, bus.b);
                            cnt_s   = CNT_MULT;
                            state_s = ST_BUSY;
                        end
                        OP_DIV: begin
                            {res_hi_s, res_lo_s} = div_zero_s ? {hi_r, lo_r} : div_signed(bus.a, bus.b);
                            cnt_s   = CNT_DIV;
                            state_s = ST_BUSY;
                        end
                        OP_DIVU: begin
                            {res_hi_s, res_lo_s} = div_zero_s ? {hi_r, lo_r} : div_unsigned(bus.a, bus.b);
                            cnt_s   = CNT_DIV;
                            state_s = ST_BUSY;
                        end
                        OP_MTHI: hi_s = bus.a;
                        OP_MTLO: lo_s = bus.a;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else begin
                    hi_s    = res_hi_r;
                    lo_s    = res_lo_r;
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, counter, HI/LO and pending-result registers; reset drops any in-flight op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            res_hi_r <= 32'd0;
            res_lo_r <= 32'd0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            res_hi_r <= res_hi_s;
            res_lo_r <= res_lo_s;
            busy_r   <= (state_s == ST_BUSY);
        end
    end

    assign bus.busy    = busy_r;
    assign bus.mdu_out = bus.read_sel ? lo_r : hi_r;
endmodule
